// File: rtl/sisr_response_compactor.sv
// Serial-input signature register (SISR) response compactor.
// Folds one response bit per accepted pattern into a signature.
// After a programmed number of patterns it compares the signature
// against a golden value that was latched at start.
module sisr_response_compactor #(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021,
    parameter logic [SIG_W-1:0] SEED  = 16'hFFFF,
    parameter int               CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_pat,
    input  logic [SIG_W-1:0] golden,
    input  logic             resp_valid,
    input  logic             resp_bit,
    output logic             resp_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [CNT_W-1:0] pat_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [SIG_W-1:0] gold_q, gold_d;
    logic             pass_q, pass_d;
    logic             accept_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [SIG_W-1:0] sig_next_s;

    // One SISR step: shift left (MSB dropped, LSB zero-filled), XOR POLY when feedback is set.
    function automatic logic [SIG_W-1:0] sisr_step(input logic [SIG_W-1:0] sig_in,
                                                   input logic             bit_in);
        logic fb;
        fb = sig_in[SIG_W-1] ^ bit_in;
        return {sig_in[SIG_W-2:0], 1'b0} ^ (fb ? POLY : {SIG_W{1'b0}});
    endfunction

    // Accept is gated only by registered state, so resp_ready never depends on resp_valid.
    assign accept_s   = resp_valid & (state_q == ST_RUN);
    assign cnt_inc_s  = cnt_q + CNT_W'(1'b1);
    assign sig_next_s = sisr_step(sig_q, resp_bit);

    // Next-state and datapath decision for the IDLE/RUN/DONE controller.
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        gold_d  = gold_q;
        pass_d  = pass_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    num_d  = num_pat;
                    gold_d = golden;
                    sig_d  = SEED;
                    cnt_d  = {CNT_W{1'b0}};
                    if (num_pat == {CNT_W{1'b0}}) begin
                        state_d = ST_DONE;
                        pass_d  = (SEED == golden);
                    end else begin
                        state_d = ST_RUN;
                        pass_d  = 1'b0;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (accept_s) begin
                    sig_d = sig_next_s;
                    cnt_d = cnt_inc_s;
                    if (cnt_inc_s == num_q) begin
                        state_d = ST_DONE;
                        pass_d  = (sig_next_s == gold_q);
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sig_d   = SEED;
                cnt_d   = {CNT_W{1'b0}};
                pass_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sig_q   <= SEED;
            cnt_q   <= {CNT_W{1'b0}};
            num_q   <= {CNT_W{1'b0}};
            gold_q  <= {SIG_W{1'b0}};
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            gold_q  <= gold_d;
            pass_q  <= pass_d;
        end
    end

    assign resp_ready = (state_q == ST_RUN);
    assign busy       = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign pass       = pass_q;
    assign signature  = sig_q;
    assign pat_count  = cnt_q;

endmodule

// File: tb/tb_sisr_response_compactor.sv
// Scoreboard bench for sisr_response_compactor: stimulus pushes expected run
// results; a monitor pops and compares whenever done is newly presented.
module tb_sisr_response_compactor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_pat = 16'd0;
    logic [15:0] golden = 16'd0;
    logic        resp_valid = 1'b0;
    logic        resp_bit = 1'b0;
    logic        resp_ready, busy, done, pass;
    logic [15:0] signature, pat_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] sig;
        logic        pas;
        logic [15:0] cnt;
    } exp_t;
    exp_t sb[$];

    sisr_response_compactor dut (
        .clk(clk), .rst(rst), .start(start), .num_pat(num_pat), .golden(golden),
        .resp_valid(resp_valid), .resp_bit(resp_bit), .resp_ready(resp_ready),
        .busy(busy), .done(done), .pass(pass), .signature(signature), .pat_count(pat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: signature as polynomial division, integer arithmetic over the bit list.
    function automatic logic [15:0] model_sig(input logic bits[$]);
        int s;
        s = 32'hFFFF;
        foreach (bits[i]) begin
            s = s * 2;
            if (((s >> 16) & 1) != int'(bits[i])) s = s ^ 32'h1021;
            s = s & 32'hFFFF;
        end
        return s[15:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] np, input logic [15:0] gold);
        start = 1'b1; num_pat = np; golden = gold;
        tick();
        start = 1'b0; num_pat = $urandom; golden = $urandom;
    endtask

    task automatic send_bit(input logic b);
        resp_valid = 1'b1; resp_bit = b;
        tick();
        resp_valid = 1'b0; resp_bit = $urandom_range(0, 1);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done && k < 20) begin
            tick();
            k++;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_done: got timeout expected done");
        end
    endtask

    task automatic push_exp(input logic [15:0] s, input logic p, input logic [15:0] c);
        exp_t e;
        e.sig = s; e.pas = p; e.cnt = c;
        sb.push_back(e);
    endtask

    // Monitor: a fresh DONE presentation (rise, or restart that lands directly in DONE).
    logic done_prev = 1'b0;
    logic start_prev = 1'b0;
    always @(negedge clk) begin
        if (done === 1'b1 && (!done_prev || start_prev)) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_empty: got done expected no run");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("mon_sig", {16'd0, signature}, {16'd0, e.sig});
                check("mon_pass", {31'd0, pass}, {31'd0, e.pas});
                check("mon_cnt", {16'd0, pat_count}, {16'd0, e.cnt});
            end
        end
        done_prev  <= done;
        start_prev <= start & ~rst;
    end

    // Directed scenarios followed by randomized runs.
    initial begin
        logic q[$];
        logic [15:0] s;
        logic [15:0] g;
        int np;
        tick(); tick();
        rst = 1'b0;
        check("rst_sig", {16'd0, signature}, 32'hFFFF);
        check("rst_cnt", {16'd0, pat_count}, 32'd0);
        check("rst_flags", {28'd0, resp_ready, busy, done, pass}, 32'd0);

        // Single bit 0 -> EFDF pass
        push_exp(16'hEFDF, 1'b1, 16'd1);
        do_start(16'd1, 16'hEFDF);
        check("t1_ready", {31'd0, resp_ready}, 32'd1);
        send_bit(1'b0);
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_sig", {16'd0, signature}, 32'hEFDF);

        // Single bit 1 -> FFFE fail
        push_exp(16'hFFFE, 1'b0, 16'd1);
        do_start(16'd1, 16'hEFDF);
        send_bit(1'b1);
        check("t2_pass", {31'd0, pass}, 32'd0);

        // Two bits with a 3-cycle gap
        push_exp(16'hCF9F, 1'b0, 16'd2);
        do_start(16'd2, 16'h1234);
        send_bit(1'b0);
        check("t3_cnt1", {16'd0, pat_count}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_gap_sig", {16'd0, signature}, 32'hEFDF);
            check("t3_gap_done", {31'd0, done}, 32'd0);
        end
        send_bit(1'b0);
        check("t3_sig", {16'd0, signature}, 32'hCF9F);
        check("t3_cnt2", {16'd0, pat_count}, 32'd2);

        // num_pat = 0 from DONE -> immediate DONE, pass
        push_exp(16'hFFFF, 1'b1, 16'd0);
        do_start(16'd0, 16'hFFFF);
        check("t4_done", {31'd0, done}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            resp_valid = 1'b1;
            tick();
            check("t4_ready", {31'd0, resp_ready}, 32'd0);
        end
        resp_valid = 1'b0;
        check("t4_cnt", {16'd0, pat_count}, 32'd0);

        // Reset mid-run
        do_start(16'd8, 16'h0000);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_sig", {16'd0, signature}, 32'hFFFF);
        check("t5_cnt", {16'd0, pat_count}, 32'd0);
        check("t5_flags", {28'd0, resp_ready, busy, done, pass}, 32'd0);
        push_exp(16'hEFDF, 1'b1, 16'd1);
        do_start(16'd1, 16'hEFDF);
        send_bit(1'b0);

        // start in RUN ignored; then rerun from DONE
        q = {1'b1, 1'b0, 1'b1, 1'b1};
        s = model_sig(q);
        for (int r = 0; r < 2; r++) begin
            push_exp(s, 1'b1, 16'd4);
            do_start(16'd4, s);
            send_bit(q[0]);
            do_start(16'd3, 16'h0000);
            for (int i = 1; i < 4; i++) send_bit(q[i]);
            check("t6_done", {31'd0, done}, 32'd1);
        end

        // Randomized runs with gaps and stray bits outside RUN
        for (int r = 0; r < 30; r++) begin
            np = $urandom_range(1, 40);
            q = {};
            for (int i = 0; i < np; i++) q.push_back(1'($urandom_range(0, 1)));
            s = model_sig(q);
            g = ($urandom_range(0, 1) == 1) ? s : 16'($urandom);
            push_exp(s, (g == s), 16'(np));
            do_start(16'(np), g);
            foreach (q[i]) begin
                for (int k = $urandom_range(0, 2); k > 0; k--) tick();
                send_bit(q[i]);
            end
            wait_done();
            for (int k = $urandom_range(0, 3); k > 0; k--) begin
                resp_valid = 1'b1; resp_bit = 1'($urandom_range(0, 1));
                tick();
            end
            resp_valid = 1'b0;
        end

        tick(); tick();
        check("sb_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
